// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into single press events, queues one per button
// and arbitrates them round-robin. Optional auto-repeat: BUTTON_EVENT_REPEAT_EN.
module button_event_arbiter #(
    parameter int N_BUTTONS     = 4,
    parameter int REPEAT_DELAY  = 25,
    parameter int REPEAT_PERIOD = 5,
    localparam int IDX_BITS     = $clog2(N_BUTTONS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic                 event_valid,
    output logic [IDX_BITS-1:0]  event_index,
    input  logic                 event_ready,
    output logic                 overrun
);

    logic [N_BUTTONS-1:0] prev_reg;
    logic [N_BUTTONS-1:0] pending_reg, pending_next;
    logic                 valid_reg, valid_next;
    logic [IDX_BITS-1:0]  index_reg, index_next;
    logic [IDX_BITS-1:0]  ptr_reg, ptr_next;
    logic                 overrun_reg, overrun_next;

    logic [N_BUTTONS-1:0] rise;
    logic [N_BUTTONS-1:0] granted;
    logic [N_BUTTONS-1:0] repeat_set;
    logic                 slot_free;
    logic                 found;
    logic                 grant;
    logic [IDX_BITS-1:0]  sel_idx;
    logic [IDX_BITS:0]    cand_sum;
    logic [IDX_BITS-1:0]  cand_idx;

    assign rise      = buttons & ~prev_reg;
    assign slot_free = ~valid_reg | event_ready;
    assign grant     = slot_free & found;

    // Round-robin search starting just after the last granted button.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        cand_sum = '0;
        cand_idx = '0;
        for (int k = 1; k <= N_BUTTONS; k++) begin
            cand_sum = {1'b0, ptr_reg} + (IDX_BITS+1)'(k);
            if (cand_sum >= (IDX_BITS+1)'(N_BUTTONS))
                cand_sum = cand_sum - (IDX_BITS+1)'(N_BUTTONS);
            cand_idx = cand_sum[IDX_BITS-1:0];
            if (!found && pending_reg[cand_idx]) begin
                found   = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_grant
            assign granted[gi] = grant && (sel_idx == IDX_BITS'(gi));
        end
    endgenerate

    always_comb begin
        pending_next = (pending_reg & ~granted) | rise | repeat_set;
        // A press only counts as lost when it lands on a pending bit that stays queued.
        overrun_next = overrun_reg | (|(rise & pending_reg & ~granted));
        valid_next   = valid_reg;
        index_next   = index_reg;
        ptr_next     = ptr_reg;
        if (slot_free) begin
            valid_next = found;
            if (found) begin
                index_next = sel_idx;
                ptr_next   = sel_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        prev_reg <= buttons;
        if (!reset_n) begin
            pending_reg <= '0;
            valid_reg   <= 1'b0;
            index_reg   <= '0;
            ptr_reg     <= IDX_BITS'(N_BUTTONS - 1);
            overrun_reg <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            valid_reg   <= valid_next;
            index_reg   <= index_next;
            ptr_reg     <= ptr_next;
            overrun_reg <= overrun_next;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic             rpt_first_reg, rpt_first_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_limit;
    logic             one_hot;

    always_comb begin
        repeat_set     = '0;
        rpt_cnt_next   = rpt_cnt_reg;
        rpt_first_next = rpt_first_reg;
        one_hot   = (buttons != '0) && ((buttons & (buttons - N_BUTTONS'(1))) == '0);
        cnt_inc   = rpt_cnt_reg + CNT_W'(1);
        cnt_limit = rpt_first_reg ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);
        if (buttons != prev_reg) begin
            rpt_cnt_next   = '0;
            rpt_first_next = 1'b1;
        end else if (one_hot) begin
            if (cnt_inc == cnt_limit) begin
                repeat_set     = buttons;
                rpt_cnt_next   = '0;
                rpt_first_next = 1'b0;
            end else begin
                rpt_cnt_next = cnt_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rpt_cnt_reg   <= '0;
            rpt_first_reg <= 1'b1;
        end else begin
            rpt_cnt_reg   <= rpt_cnt_next;
            rpt_first_reg <= rpt_first_next;
        end
    end
`else
    logic unused_repeat_cfg;
    assign repeat_set        = '0;
    assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
`endif

    assign event_valid = valid_reg;
    assign event_index = index_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed vector table plus hand sequences for the round-robin button event arbiter.
module tb_button_event_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] buttons;
    logic       event_valid;
    logic [1:0] event_index;
    logic       event_ready;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    button_event_arbiter #(
        .N_BUTTONS    (4),
        .REPEAT_DELAY (25),
        .REPEAT_PERIOD(5)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .buttons    (buttons),
        .event_valid(event_valid),
        .event_index(event_index),
        .event_ready(event_ready),
        .overrun    (overrun)
    );

    typedef struct {
        logic [3:0] b;
        logic       rdy;
        logic       rst_n;
        logic       v;
        logic [1:0] i;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] b, input logic rdy, input logic rst_n,
                                input logic v, input logic [1:0] i, input logic ov);
        vec_t r;
        r.b = b; r.rdy = rdy; r.rst_n = rst_n; r.v = v; r.i = i; r.ov = ov;
        vecs.push_back(r);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        buttons     = 4'b0010;
        event_ready = 1'b1;
        tick();
        tick();
        chk("reset_valid", 8'(event_valid), 8'd0);
        chk("reset_index", 8'(event_index), 8'd0);
        chk("reset_overrun", 8'(overrun), 8'd0);

`ifndef BUTTON_EVENT_REPEAT_EN
        // Button held through reset must never produce an event.
        reset_n = 1'b1;
        for (int t = 0; t < 50; t++) begin
            tick();
            chk("held_through_reset_valid", 8'(event_valid), 8'd0);
        end
        chk("held_through_reset_overrun", 8'(overrun), 8'd0);
        $display("txn held_through_reset buttons=%b valid=%b overrun=%b", buttons, event_valid, overrun);
`endif
        reset_n = 1'b1;
        buttons = 4'b0000;
        tick();
        tick();

        // Single press, then simultaneous presses with back-pressure, then rotation.
        add(4'b0100, 1, 1, 0, 2'd0, 0);
        add(4'b0100, 1, 1, 1, 2'd2, 0);
        add(4'b0100, 1, 1, 0, 2'd2, 0);
        add(4'b0000, 1, 1, 0, 2'd2, 0);
        add(4'b0000, 1, 0, 0, 2'd0, 0);
        add(4'b1011, 0, 1, 0, 2'd0, 0);
        for (int n = 0; n < 11; n++) add(4'b1011, 0, 1, 1, 2'd0, 0);
        add(4'b1011, 1, 1, 1, 2'd1, 0);
        add(4'b1011, 1, 1, 1, 2'd3, 0);
        add(4'b1011, 1, 1, 0, 2'd3, 0);
        add(4'b0000, 1, 1, 0, 2'd3, 0);
        add(4'b0010, 1, 1, 0, 2'd3, 0);
        add(4'b0010, 0, 1, 1, 2'd1, 0);
        add(4'b0111, 0, 1, 1, 2'd1, 0);
        add(4'b0111, 1, 1, 1, 2'd2, 0);
        add(4'b0111, 1, 1, 1, 2'd0, 0);
        add(4'b0111, 1, 1, 0, 2'd0, 0);
        add(4'b0000, 1, 1, 0, 2'd0, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            buttons     = vecs[n].b;
            event_ready = vecs[n].rdy;
            reset_n     = vecs[n].rst_n;
            tick();
            $display("vec %0d buttons=%b ready=%b rst_n=%b valid=%b index=%0d overrun=%b",
                     n, vecs[n].b, vecs[n].rdy, vecs[n].rst_n, event_valid, event_index, overrun);
            chk($sformatf("vec%0d_valid", n), 8'(event_valid), 8'(vecs[n].v));
            chk($sformatf("vec%0d_index", n), 8'(event_index), 8'(vecs[n].i));
            chk($sformatf("vec%0d_overrun", n), 8'(overrun), 8'(vecs[n].ov));
        end

        // Overrun: press, release, press again while still pending.
        reset_n = 1'b0; buttons = 4'b0000; event_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        buttons = 4'b0001; tick(); tick();
        chk("ovr_present0_valid", 8'(event_valid), 8'd1);
        chk("ovr_present0_index", 8'(event_index), 8'd0);
        buttons = 4'b0011; tick();
        buttons = 4'b0001; tick();
        buttons = 4'b0011; tick();
        chk("ovr_set", 8'(overrun), 8'd1);
        chk("ovr_hold_index", 8'(event_index), 8'd0);
        event_ready = 1'b1; tick();
        chk("ovr_event1_valid", 8'(event_valid), 8'd1);
        chk("ovr_event1_index", 8'(event_index), 8'd1);
        tick();
        chk("ovr_single_event", 8'(event_valid), 8'd0);
        chk("ovr_sticky", 8'(overrun), 8'd1);
        $display("txn overrun_seq valid=%b index=%0d overrun=%b", event_valid, event_index, overrun);
        reset_n = 1'b0; tick();
        chk("ovr_reset_clear", 8'(overrun), 8'd0);
        chk("ovr_reset_valid", 8'(event_valid), 8'd0);

        // Reset in the middle of a handshake discards the presented and pending events.
        reset_n = 1'b1; event_ready = 1'b0; buttons = 4'b0000; tick();
        buttons = 4'b0100; tick();
        buttons = 4'b0110; tick();
        chk("mid_present_valid", 8'(event_valid), 8'd1);
        chk("mid_present_index", 8'(event_index), 8'd2);
        reset_n = 1'b0; buttons = 4'b0000; tick();
        reset_n = 1'b1; event_ready = 1'b1; tick(); tick();
        chk("mid_discard_valid", 8'(event_valid), 8'd0);
        $display("txn reset_mid_handshake valid=%b", event_valid);

        // Re-press of the presented button queues again without overrun.
        event_ready = 1'b0;
        buttons = 4'b0001; tick(); tick();
        buttons = 4'b0000; tick();
        buttons = 4'b0001; tick();
        chk("requeue_no_overrun", 8'(overrun), 8'd0);
        chk("requeue_hold_index", 8'(event_index), 8'd0);
        event_ready = 1'b1; tick();
        chk("requeue_event_valid", 8'(event_valid), 8'd1);
        chk("requeue_event_index", 8'(event_index), 8'd0);
        tick();
        chk("requeue_done", 8'(event_valid), 8'd0);
        $display("txn requeue valid=%b overrun=%b", event_valid, overrun);

`ifdef BUTTON_EVENT_REPEAT_EN
        begin
            int evts;
            reset_n = 1'b0; buttons = 4'b0000; event_ready = 1'b1; tick();
            reset_n = 1'b1; tick();
            buttons = 4'b1000;
            for (int t = 1; t <= 40; t++) begin
                tick();
                chk($sformatf("rpt_t%0d_valid", t), 8'(event_valid),
                    8'((t == 2) || (t == 27) || (t == 32) || (t == 37)));
                if (event_valid) chk($sformatf("rpt_t%0d_index", t), 8'(event_index), 8'd3);
            end
            buttons = 4'b1001;
            evts = 0;
            for (int t = 1; t <= 40; t++) begin
                tick();
                if (event_valid) evts++;
            end
            chk("rpt_stopped_by_second", 8'(evts), 8'd1);
            $display("txn repeat_seq events_after_second=%0d", evts);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
